// File: rtl/rv32m_execute.sv
// rv32m_execute: RV32M execute stage for the RISC-MGMT framework.
// Computes MUL/MULH/MULHSU/MULHU with an iterative shift-add multiplier and
// DIV/DIVU/REM/REMU with a restoring divider, stalling the core via busy.
//
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   start            decoded RV32M instruction present (held while busy)
//   funct3           operation select
//   rs1_data/rs2_data source operands
//   busy             combinational stall request
//   reg_w/reg_wdata  one-cycle register write strobe and data
//   exception        always 0
//   exmem            registered bundle to the memory stage
//
// Build option: define RV32M_FAST_MUL_EN for a single-cycle combinational
// multiplier (multiplies complete in 1 cycle; divides unchanged).

package rv32m_pkg;
   localparam int unsigned XLEN = 32;

   typedef struct packed {
      logic            valid;
      logic [2:0]      funct3;
      logic [XLEN-1:0] wdata;
   } execute_memory_t;
endpackage

module rv32m_execute (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       start,
   input  logic [2:0]                 funct3,
   input  logic [31:0]                rs1_data,
   input  logic [31:0]                rs2_data,
   output logic                       busy,
   output logic                       reg_w,
   output logic [31:0]                reg_wdata,
   output logic                       exception,
   output rv32m_pkg::execute_memory_t exmem
);
   import rv32m_pkg::*;

   localparam int unsigned W     = 32;
   localparam int unsigned CNT_W = 6;

   localparam logic [2:0] S_IDLE = 3'd0;
`ifndef RV32M_FAST_MUL_EN
   localparam logic [2:0] S_MUL  = 3'd1;
`endif
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [W-1:0]     mcand_q, mcand_d;
   logic [2:0]       funct3_q, funct3_d;
   logic             sign1_q, sign1_d;
   logic             sign2_q, sign2_d;
   logic             reg_w_q, reg_w_d;
   logic [W-1:0]     reg_wdata_q, reg_wdata_d;
   execute_memory_t  exmem_q, exmem_d;

   // Operand signedness and magnitudes from the incoming instruction
   logic         op_signed1, op_signed2;
   logic         s1_in, s2_in;
   logic [W-1:0] mag1, mag2;

   assign op_signed1 = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
   assign op_signed2 = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
   assign s1_in      = op_signed1 & rs1_data[W-1];
   assign s2_in      = op_signed2 & rs2_data[W-1];
   assign mag1       = s1_in ? (-rs1_data) : rs1_data;
   assign mag2       = s2_in ? (-rs2_data) : rs2_data;

   // Divide special cases resolved without iterating
   logic         div_by_zero, div_ovf;
   logic [W-1:0] fast_div_res;

   assign div_by_zero  = (rs2_data == '0);
   assign div_ovf      = ~funct3[0] && (rs1_data == 32'h8000_0000) &&
                         (rs2_data == 32'hFFFF_FFFF);
   assign fast_div_res = div_by_zero ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF)
                                     : (funct3[1] ? 32'h0 : 32'h8000_0000);

`ifdef RV32M_FAST_MUL_EN
   // Single-cycle product; low 64 bits of the sign/zero-extended product
   logic signed [W:0]     op1_sx, op2_sx;
   logic signed [2*W-1:0] fast_prod;
   logic [W-1:0]          fast_mul_res;

   assign op1_sx       = $signed({s1_in, rs1_data});
   assign op2_sx       = $signed({s2_in, rs2_data});
   assign fast_prod    = 64'(op1_sx) * 64'(op2_sx);
   assign fast_mul_res = (funct3 == 3'b000) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
`else
   // Shift-add step: multiplier sits in acc low half, product grows from the top
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : 33'h0);
   assign mul_next = {mul_sum, acc_q[W-1:1]};
`endif

   // Restoring divide step: acc = {remainder, dividend/quotient}
   logic [W:0]     rem_sh, rem_diff;
   logic [2*W-1:0] div_next;

   assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
   assign rem_diff = rem_sh - {1'b0, mcand_q};
   assign div_next = rem_diff[W] ? {rem_sh[W-1:0],   acc_q[W-2:0], 1'b0}
                                 : {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};

   // Sign fix-up and result selection
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix, rem_fix, fix_res;

   assign prod_fix = (sign1_q ^ sign2_q) ? (-acc_q) : acc_q;
   assign quo_fix  = (sign1_q ^ sign2_q) ? (-acc_q[W-1:0]) : acc_q[W-1:0];
   assign rem_fix  = sign1_q ? (-acc_q[2*W-1:W]) : acc_q[2*W-1:W];

   always_comb begin
      fix_res = quo_fix;
      case (funct3_q)
         3'b000:                 fix_res = prod_fix[W-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
         3'b100, 3'b101:         fix_res = quo_fix;
         default:                fix_res = rem_fix;
      endcase
   end

   // Next-state and registered-output logic
   logic         load_res;
   logic [W-1:0] fin_res;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      mcand_d      = mcand_q;
      funct3_d     = funct3_q;
      sign1_d      = sign1_q;
      sign2_d      = sign2_q;
      reg_w_d      = 1'b0;
      reg_wdata_d  = reg_wdata_q;
      exmem_d      = exmem_q;
      exmem_d.valid = 1'b0;
      load_res     = 1'b0;
      fin_res      = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               funct3_d = funct3;
               sign1_d  = s1_in;
               sign2_d  = s2_in;
               cnt_d    = '0;
               if (!funct3[2]) begin
`ifdef RV32M_FAST_MUL_EN
                  state_d  = S_DONE;
                  load_res = 1'b1;
                  fin_res  = fast_mul_res;
`else
                  acc_d    = {32'h0, mag2};
                  mcand_d  = mag1;
                  state_d  = S_MUL;
`endif
               end else if (div_by_zero || div_ovf) begin
                  state_d  = S_DONE;
                  load_res = 1'b1;
                  fin_res  = fast_div_res;
               end else begin
                  acc_d    = {32'h0, mag1};
                  mcand_d  = mag2;
                  state_d  = S_DIV;
               end
            end
         end
`ifndef RV32M_FAST_MUL_EN
         S_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) state_d = S_FIX;
         end
`endif
         S_DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            state_d  = S_DONE;
            load_res = 1'b1;
            fin_res  = fix_res;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (load_res) begin
         reg_w_d        = 1'b1;
         reg_wdata_d    = fin_res;
         exmem_d.valid  = 1'b1;
         exmem_d.funct3 = funct3_d;
         exmem_d.wdata  = fin_res;
      end
   end

   // State and output registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         funct3_q    <= '0;
         sign1_q     <= 1'b0;
         sign2_q     <= 1'b0;
         reg_w_q     <= 1'b0;
         reg_wdata_q <= '0;
         exmem_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         funct3_q    <= funct3_d;
         sign1_q     <= sign1_d;
         sign2_q     <= sign2_d;
         reg_w_q     <= reg_w_d;
         reg_wdata_q <= reg_wdata_d;
         exmem_q     <= exmem_d;
      end
   end

   // Stall in the same cycle start appears; released during DONE and in reset
`ifdef RV32M_FAST_MUL_EN
   assign busy = nRST & ((state_q == S_DIV) || (state_q == S_FIX) ||
                         ((state_q == S_IDLE) && start));
`else
   assign busy = nRST & ((state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX) ||
                         ((state_q == S_IDLE) && start));
`endif

   assign reg_w     = reg_w_q;
   assign reg_wdata = reg_wdata_q;
   assign exmem     = exmem_q;
   assign exception = 1'b0;

endmodule
